// File: rtl/ProcTypes.sv
// Instruction classes produced by the RV32I decoder and consumed by the control sequencer.
package ProcTypes;

  typedef enum logic [3:0] {
    Unsupported,
    OP,
    OPIMM,
    LUI,
    AUIPC,
    JAL,
    JALR,
    BRANCH,
    LOAD,
    STORE,
    PMUL
  } IType;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/MUL/WB control for the basic RV32I core.
// Define CORE_SEQ_PMUL_EN to enable the PMUL path; without it PMUL decodes as Unsupported.
module core_sequencer
  import ProcTypes::*;
#(
  parameter logic [31:0] RESET_INSTRET = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  IType        itype_in,
  input  logic        br_taken_in,
  input  logic        imem_rvalid_in,
  input  logic        dmem_rvalid_in,
  input  logic        mul_done_in,
  output logic        imem_req_out,
  output logic        ir_we_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic        mul_start_out,
  output logic        rf_we_out,
  output logic        pc_we_out,
  output logic [1:0]  pc_sel_out,
  output logic        busy_out,
  output logic        trap_out,
  output logic [31:0] instret_out
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StMul, StWb, StTrap
  } state_e;

  state_e      state_q, state_d;
  IType        itype_q, itype_d;
  logic [31:0] instret_q;

`ifndef CORE_SEQ_PMUL_EN
  logic unused_mul_done;
  assign unused_mul_done = mul_done_in;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      itype_q   <= Unsupported;
      instret_q <= RESET_INSTRET;
    end else begin
      state_q <= state_d;
      itype_q <= itype_d;
      // Every retire is marked by a PC update; the counter wraps naturally.
      if (pc_we_out) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    itype_d       = itype_q;
    imem_req_out  = 1'b0;
    ir_we_out     = 1'b0;
    dmem_req_out  = 1'b0;
    dmem_we_out   = 1'b0;
    mul_start_out = 1'b0;
    rf_we_out     = 1'b0;
    pc_we_out     = 1'b0;
    pc_sel_out    = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (start_in) state_d = StFetch;
      end
      StFetch: begin
        imem_req_out = 1'b1;
        if (imem_rvalid_in) begin
          ir_we_out = 1'b1;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        itype_d = itype_in;
        case (itype_in)
          OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE: state_d = StExec;
`ifdef CORE_SEQ_PMUL_EN
          PMUL: state_d = StExec;
`endif
          default: state_d = StTrap;
        endcase
      end
      StExec: begin
        case (itype_q)
          OP, OPIMM, LUI, AUIPC, JAL, JALR: state_d = StWb;
          LOAD: state_d = StMem;
          STORE: begin
            dmem_we_out = 1'b1;
            state_d     = StMem;
          end
          BRANCH: begin
            pc_we_out  = 1'b1;
            pc_sel_out = br_taken_in ? 2'd1 : 2'd0;
            state_d    = StFetch;
          end
`ifdef CORE_SEQ_PMUL_EN
          PMUL: begin
            mul_start_out = 1'b1;
            state_d       = StMul;
          end
`endif
          default: state_d = StTrap;
        endcase
      end
      StMem: begin
        dmem_req_out = 1'b1;
        dmem_we_out  = (itype_q == STORE);
        if (dmem_rvalid_in) begin
          if (itype_q == STORE) begin
            pc_we_out = 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
`ifdef CORE_SEQ_PMUL_EN
      StMul: begin
        if (mul_done_in) state_d = StWb;
      end
`endif
      StWb: begin
        rf_we_out = 1'b1;
        pc_we_out = 1'b1;
        if (itype_q == JAL) begin
          pc_sel_out = 2'd1;
        end else if (itype_q == JALR) begin
          pc_sel_out = 2'd2;
        end
        state_d = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_out    = (state_q != StIdle) && (state_q != StTrap);
  assign trap_out    = (state_q == StTrap);
  assign instret_out = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instruction stream, retire-time checking.
module tb_core_sequencer;
  import ProcTypes::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  IType        itype_in;
  logic        br_taken_in;
  logic        imem_rvalid_in;
  logic        dmem_rvalid_in;
  logic        mul_done_in;
  logic        imem_req_out, ir_we_out, dmem_req_out, dmem_we_out, mul_start_out;
  logic        rf_we_out, pc_we_out, busy_out, trap_out;
  logic [1:0]  pc_sel_out;
  logic [31:0] instret_out;

  // Second instance preloaded near wrap; shares all inputs.
  logic        w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_mul_start;
  logic        w_rf_we, w_pc_we, w_busy, w_trap;
  logic [1:0]  w_pc_sel;
  logic [31:0] w_instret;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_instret;

  typedef struct {
    logic [1:0]  sel;
    logic        rf;
    int          cycles;
    int          memc;
    logic        store;
    int          mulc;
    logic [31:0] instret;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk_in = ~clk_in;

  core_sequencer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .itype_in(itype_in),
    .br_taken_in(br_taken_in), .imem_rvalid_in(imem_rvalid_in),
    .dmem_rvalid_in(dmem_rvalid_in), .mul_done_in(mul_done_in),
    .imem_req_out(imem_req_out), .ir_we_out(ir_we_out), .dmem_req_out(dmem_req_out),
    .dmem_we_out(dmem_we_out), .mul_start_out(mul_start_out), .rf_we_out(rf_we_out),
    .pc_we_out(pc_we_out), .pc_sel_out(pc_sel_out), .busy_out(busy_out),
    .trap_out(trap_out), .instret_out(instret_out)
  );

  core_sequencer #(.RESET_INSTRET(32'hFFFF_FFFF)) dut_wrap (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .itype_in(itype_in),
    .br_taken_in(br_taken_in), .imem_rvalid_in(imem_rvalid_in),
    .dmem_rvalid_in(dmem_rvalid_in), .mul_done_in(mul_done_in),
    .imem_req_out(w_imem_req), .ir_we_out(w_ir_we), .dmem_req_out(w_dmem_req),
    .dmem_we_out(w_dmem_we), .mul_start_out(w_mul_start), .rf_we_out(w_rf_we),
    .pc_we_out(w_pc_we), .pc_sel_out(w_pc_sel), .busy_out(w_busy),
    .trap_out(w_trap), .instret_out(w_instret)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Drives one instruction starting in FETCH; returns in the FETCH after its retire.
  task automatic instr(input IType t, input int iw, input int dw, input int mw, input logic br,
                       input logic [1:0] sel, input logic rf, input int cycles);
    exp_t e;
    e.sel     = sel;
    e.rf      = rf;
    e.cycles  = cycles;
    e.memc    = (t == LOAD || t == STORE) ? dw + 1 : 0;
    e.store   = (t == STORE);
    e.mulc    = (t == PMUL) ? 1 : 0;
    e.instret = exp_instret;
    exp_q.push_back(e);
    exp_instret++;
    itype_in = t;
    repeat (iw) step();
    imem_rvalid_in = 1'b1;
    step();
    imem_rvalid_in = 1'b0;
    step();
    itype_in    = Unsupported;
    br_taken_in = br;
    if (t == PMUL) mul_done_in = 1'b1;
    step();
    br_taken_in = 1'b0;
    mul_done_in = 1'b0;
    if (t == LOAD || t == STORE) begin
      repeat (dw) step();
      dmem_rvalid_in = 1'b1;
      step();
      dmem_rvalid_in = 1'b0;
      if (t == LOAD) step();
    end else if (t == PMUL) begin
      repeat (mw) step();
      mul_done_in = 1'b1;
      step();
      mul_done_in = 1'b0;
      step();
    end else if (t != BRANCH) begin
      step();
    end
  endtask

  // Monitor: per-instruction counters, popped and compared on every retire.
  initial begin : monitor
    exp_t e;
    int cyc, memc, mulc;
    cyc = 0; memc = 0; mulc = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        cyc = 0; memc = 0; mulc = 0;
      end else begin
        if (busy_out) cyc++;
        if (mul_start_out) mulc++;
        if (dmem_req_out) begin
          memc++;
          if (exp_q.size() == 0) check1("dmem_req_unexpected", dmem_req_out, 1'b0);
          else check1("dmem_we", dmem_we_out, exp_q[0].store);
        end
        if (rf_we_out && !pc_we_out) check1("rf_we_without_pc_we", rf_we_out, 1'b0);
        if (pc_we_out) begin
          if (exp_q.size() == 0) begin
            check1("retire_unexpected", pc_we_out, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check32("retire_pc_sel", 32'(pc_sel_out), 32'(e.sel));
            check1("retire_rf_we", rf_we_out, e.rf);
            check32("retire_cycles", cyc, e.cycles);
            check32("retire_mem_cycles", memc, e.memc);
            check32("retire_mul_starts", mulc, e.mulc);
            check32("retire_instret", instret_out, e.instret);
          end
          cyc = 0; memc = 0; mulc = 0;
        end
      end
    end
  end

  initial begin : stimulus
    rst_n_in = 1'b0; start_in = 1'b0; itype_in = Unsupported; br_taken_in = 1'b0;
    imem_rvalid_in = 1'b0; dmem_rvalid_in = 1'b0; mul_done_in = 1'b0;
    exp_instret = 32'd0;
    @(negedge clk_in);
    check1("rst_busy", busy_out, 1'b0);
    check1("rst_trap", trap_out, 1'b0);
    check1("rst_imem_req", imem_req_out, 1'b0);
    check1("rst_pc_we", pc_we_out, 1'b0);
    check32("rst_instret", instret_out, 32'd0);
    check32("rst_instret_wrap", w_instret, 32'hFFFF_FFFF);
    step();
    rst_n_in = 1'b1;
    // Stray rvalids in IDLE must not start anything.
    imem_rvalid_in = 1'b1; dmem_rvalid_in = 1'b1;
    step();
    imem_rvalid_in = 1'b0; dmem_rvalid_in = 1'b0;
    step();
    check1("idle_imem_req", imem_req_out, 1'b0);
    check1("idle_busy", busy_out, 1'b0);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    check1("fetch_imem_req", imem_req_out, 1'b1);
    check1("fetch_busy", busy_out, 1'b1);

    //    type    iw dw mw br    sel   rf    cycles
    instr(OP,     0, 0, 0, 1'b0, 2'd0, 1'b1, 4);
    check32("wrap_instret", w_instret, 32'd0);
    check32("instret_after_op", instret_out, 32'd1);
    check1("back_to_back_fetch", imem_req_out, 1'b1);
    instr(OP,     2, 0, 0, 1'b0, 2'd0, 1'b1, 6);
    instr(LOAD,   0, 2, 0, 1'b0, 2'd0, 1'b1, 7);
    instr(STORE,  0, 0, 0, 1'b0, 2'd0, 1'b0, 4);
    instr(BRANCH, 0, 0, 0, 1'b1, 2'd1, 1'b0, 3);
    instr(BRANCH, 0, 0, 0, 1'b0, 2'd0, 1'b0, 3);
    instr(JAL,    0, 0, 0, 1'b0, 2'd1, 1'b1, 4);
    instr(JALR,   0, 0, 0, 1'b0, 2'd2, 1'b1, 4);
    instr(LUI,    0, 0, 0, 1'b0, 2'd0, 1'b1, 4);
    instr(AUIPC,  1, 0, 0, 1'b0, 2'd0, 1'b1, 5);
    instr(OPIMM,  0, 0, 0, 1'b1, 2'd0, 1'b1, 4);
    instr(STORE,  0, 1, 0, 1'b0, 2'd0, 1'b0, 5);
    instr(LOAD,   0, 0, 0, 1'b0, 2'd0, 1'b1, 5);
`ifdef CORE_SEQ_PMUL_EN
    instr(PMUL,   0, 0, 3, 1'b0, 2'd0, 1'b1, 8);
`endif
    check32("queue_drained", exp_q.size(), 32'd0);
    check32("instret_total", instret_out, exp_instret);

    // Reset in MEM: request must drop without a clock edge.
    exp_q.push_back('{sel: 2'd0, rf: 1'b1, cycles: 5, memc: 1, store: 1'b0, mulc: 0,
                      instret: exp_instret});
    itype_in = LOAD; imem_rvalid_in = 1'b1;
    step();
    imem_rvalid_in = 1'b0;
    step();
    itype_in = Unsupported;
    step();
    check1("mem_req_before_rst", dmem_req_out, 1'b1);
    #2 rst_n_in = 1'b0;
    #1;
    check1("mem_req_async_drop", dmem_req_out, 1'b0);
    check1("mem_rst_busy", busy_out, 1'b0);
    check32("mem_rst_instret", instret_out, 32'd0);
    check32("mem_rst_instret_wrap", w_instret, 32'hFFFF_FFFF);
    exp_q.delete();
    exp_instret = 32'd0;
    step();
    rst_n_in = 1'b1;

    // Unsupported decode traps; start and rvalid are ignored afterwards.
    start_in = 1'b1;
    step();
    start_in = 1'b0; itype_in = Unsupported; imem_rvalid_in = 1'b1;
    step();
    imem_rvalid_in = 1'b0;
    step();
    check1("trap_set", trap_out, 1'b1);
    check1("trap_busy", busy_out, 1'b0);
    for (int i = 0; i < 100; i++) begin
      start_in       = (i % 10 == 0);
      imem_rvalid_in = (i % 10 == 5);
      step();
      if (i % 25 == 24) begin
        check1("trap_sticky", trap_out, 1'b1);
        check1("trap_no_busy", busy_out, 1'b0);
        check1("trap_no_req", imem_req_out, 1'b0);
      end
    end
    start_in = 1'b0; imem_rvalid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    check1("trap_async_clear", trap_out, 1'b0);
    step();
    rst_n_in = 1'b1;

`ifndef CORE_SEQ_PMUL_EN
    start_in = 1'b1;
    step();
    start_in = 1'b0; itype_in = PMUL; imem_rvalid_in = 1'b1;
    step();
    imem_rvalid_in = 1'b0;
    step();
    itype_in = Unsupported;
    check1("pmul_disabled_trap", trap_out, 1'b1);
    check1("pmul_no_mul_start", mul_start_out, 1'b0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
